// File: rtl/multi_domain_power_controller_pkg.sv
// Shared types and helpers for the multi-domain power-gating controller.
//  pgc_state_t : per-domain sequencer state
//  cnt_width() : width of the per-domain phase/timeout counter
package pgc_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        PWR_UP  = 3'd1,
        RESTORE = 3'd2,
        DEISO   = 3'd3,
        ON      = 3'd4,
        ISO     = 3'd5,
        SAVE    = 3'd6,
        PWR_DN  = 3'd7
    } pgc_state_t;

    // Counter must hold the largest of the ramp, isolation and timeout counts.
    function automatic int unsigned cnt_width(input int unsigned ramp,
                                              input int unsigned iso,
                                              input int unsigned timeout);
        int unsigned m;
        m = ramp;
        if (iso > m)     m = iso;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/multi_domain_power_controller_domain_fsm.sv
// One power domain's isolate/save/switch/restore sequencer.
//  Inputs : clk, rst (async, active-high), power_on_req, power_off_req,
//           ack_from_block, err_clr, grant (inrush-limiter permission)
//  Outputs: isolate_en, save_state, restore_state, power_switch_en,
//           power_on_ack, power_off_ack, domain_on, err_timeout (all registered),
//           up_pend (registered pending power-up request),
//           pwr_up_next_c (next state is PWR_UP, used by the top's busy flop)
module pgc_domain_fsm
    import pgc_pkg::*;
#(
    parameter int unsigned RAMP_CYCLES    = 16,
    parameter int unsigned ISO_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic power_on_req,
    input  logic power_off_req,
    input  logic ack_from_block,
    input  logic err_clr,
    input  logic grant,
    output logic isolate_en,
    output logic save_state,
    output logic restore_state,
    output logic power_switch_en,
    output logic power_on_ack,
    output logic power_off_ack,
    output logic domain_on,
    output logic err_timeout,
    output logic up_pend,
    output logic pwr_up_next_c
);

    localparam int unsigned CW = cnt_width(RAMP_CYCLES, ISO_CYCLES, TIMEOUT_CYCLES);

    pgc_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          up_pend_q, up_pend_d;
    logic          err_q, err_d;
    logic          iso_q, sw_q, save_q, restore_q, on_q, on_ack_q, off_ack_q;

    // Next-state, counter, pending-request and error-flag logic.
    always_comb begin
        state_d   = state_q;
        up_pend_d = up_pend_q;
        err_d     = err_q & ~err_clr;
        // Saturating count of cycles spent in the current state.
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            OFF: begin
                if (power_on_req) up_pend_d = 1'b1;
                if (up_pend_q && grant) begin
                    state_d   = PWR_UP;
                    up_pend_d = 1'b0;
                end
            end
            PWR_UP: begin
                if (cnt_q == CW'(RAMP_CYCLES - 1)) state_d = RESTORE;
            end
            RESTORE: begin
                // A timed-out restore still proceeds: the domain is powered.
                if (ack_from_block) begin
                    state_d = DEISO;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DEISO;
                end
            end
            DEISO: state_d = ON;
            ON: begin
                if (power_off_req) state_d = ISO;
            end
            ISO: begin
                if (cnt_q == CW'(ISO_CYCLES - 1)) state_d = SAVE;
            end
            SAVE: begin
                // A timed-out save aborts back to ON; the supply stays up.
                if (ack_from_block) begin
                    state_d = PWR_DN;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DEISO;
                end
            end
            PWR_DN:  state_d = OFF;
            default: state_d = OFF;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            up_pend_q <= 1'b0;
            err_q     <= 1'b0;
            iso_q     <= 1'b1;
            sw_q      <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            on_q      <= 1'b0;
            on_ack_q  <= 1'b0;
            off_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            up_pend_q <= up_pend_d;
            err_q     <= err_d;
            iso_q     <= (state_d != ON);
            sw_q      <= (state_d != OFF) && (state_d != PWR_DN);
            save_q    <= (state_d == SAVE);
            restore_q <= (state_d == RESTORE);
            on_q      <= (state_d == ON);
            on_ack_q  <= (state_d == ON) && (state_q != ON);
            off_ack_q <= (state_d == OFF) && (state_q == PWR_DN);
        end
    end

    assign isolate_en      = iso_q;
    assign power_switch_en = sw_q;
    assign save_state      = save_q;
    assign restore_state   = restore_q;
    assign domain_on       = on_q;
    assign power_on_ack    = on_ack_q;
    assign power_off_ack   = off_ack_q;
    assign err_timeout     = err_q;
    assign up_pend         = up_pend_q;
    assign pwr_up_next_c   = (state_d == PWR_UP);

endmodule

// File: rtl/multi_domain_power_controller.sv
// Power-gating sequencer for NUM_DOMAINS independently switchable domains with
// a shared inrush limiter (one domain ramping at a time, index 0 highest).
//  Inputs : clk, rst (async, active-high), power_on_req[N], power_off_req[N],
//           ack_from_block[N], err_clr[N]
//  Outputs: isolate_en[N], save_state[N], restore_state[N], power_switch_en[N],
//           power_on_ack[N], power_off_ack[N], domain_on[N], err_timeout[N],
//           ramp_busy
module multi_domain_power_controller
    import pgc_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned RAMP_CYCLES    = 16,
    parameter int unsigned ISO_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DOMAINS-1:0] power_on_req,
    input  logic [NUM_DOMAINS-1:0] power_off_req,
    input  logic [NUM_DOMAINS-1:0] ack_from_block,
    input  logic [NUM_DOMAINS-1:0] err_clr,
    output logic [NUM_DOMAINS-1:0] isolate_en,
    output logic [NUM_DOMAINS-1:0] save_state,
    output logic [NUM_DOMAINS-1:0] restore_state,
    output logic [NUM_DOMAINS-1:0] power_switch_en,
    output logic [NUM_DOMAINS-1:0] power_on_ack,
    output logic [NUM_DOMAINS-1:0] power_off_ack,
    output logic [NUM_DOMAINS-1:0] domain_on,
    output logic [NUM_DOMAINS-1:0] err_timeout,
    output logic                   ramp_busy
);

    logic [NUM_DOMAINS-1:0] up_pend;
    logic [NUM_DOMAINS-1:0] pwr_up_next_c;
    logic [NUM_DOMAINS-1:0] grant_c;
    logic                   ramp_busy_q, ramp_busy_d;
    logic                   lower_pend;

    // Fixed-priority grant; ramp_busy_q is exactly "some domain is in PWR_UP".
    always_comb begin
        grant_c    = '0;
        lower_pend = 1'b0;
        for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
            grant_c[i] = up_pend[i] & ~ramp_busy_q & ~lower_pend;
            lower_pend = lower_pend | up_pend[i];
        end
        ramp_busy_d = |pwr_up_next_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ramp_busy_q <= 1'b0;
        else     ramp_busy_q <= ramp_busy_d;
    end

    assign ramp_busy = ramp_busy_q;

    for (genvar g = 0; g < int'(NUM_DOMAINS); g++) begin : g_dom
        pgc_domain_fsm #(
            .RAMP_CYCLES    (RAMP_CYCLES),
            .ISO_CYCLES     (ISO_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_fsm (
            .clk             (clk),
            .rst             (rst),
            .power_on_req    (power_on_req[g]),
            .power_off_req   (power_off_req[g]),
            .ack_from_block  (ack_from_block[g]),
            .err_clr         (err_clr[g]),
            .grant           (grant_c[g]),
            .isolate_en      (isolate_en[g]),
            .save_state      (save_state[g]),
            .restore_state   (restore_state[g]),
            .power_switch_en (power_switch_en[g]),
            .power_on_ack    (power_on_ack[g]),
            .power_off_ack   (power_off_ack[g]),
            .domain_on       (domain_on[g]),
            .err_timeout     (err_timeout[g]),
            .up_pend         (up_pend[g]),
            .pwr_up_next_c   (pwr_up_next_c[g])
        );
    end

endmodule

// File: tb/tb_multi_domain_power_controller.sv
// Self-checking bench: a time-stamped phase model of each domain predicts every
// output after every clock edge; directed scenarios pin the model to literals.
module tb_multi_domain_power_controller;

    localparam int N    = 4;
    localparam int RAMP = 16;
    localparam int ISOC = 2;
    localparam int TMO  = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] on_req, off_req, ack, clr;
    logic [N-1:0] isolate_en, save_state, restore_state, power_switch_en;
    logic [N-1:0] power_on_ack, power_off_ack, domain_on, err_timeout;
    logic         ramp_busy;

    multi_domain_power_controller #(
        .NUM_DOMAINS(N), .RAMP_CYCLES(RAMP), .ISO_CYCLES(ISOC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .power_on_req(on_req), .power_off_req(off_req),
        .ack_from_block(ack), .err_clr(clr),
        .isolate_en(isolate_en), .save_state(save_state),
        .restore_state(restore_state), .power_switch_en(power_switch_en),
        .power_on_ack(power_on_ack), .power_off_ack(power_off_ack),
        .domain_on(domain_on), .err_timeout(err_timeout), .ramp_busy(ramp_busy)
    );

    always #5 clk = ~clk;

    // Model: each domain is in a phase entered at edge t0; phase lengths are
    // judged by elapsed edges since entry.
    typedef enum int {M_OFF, M_RAMP, M_REST, M_DEISO, M_ON, M_ISO, M_SAVE, M_DN} mphase_t;
    mphase_t ph[N];
    int      t0[N];
    bit      pend[N];
    bit      err[N];
    bit      from_dn[N];
    int      cyc;
    int      checks;
    int      errors;

    function automatic void model_reset();
        for (int d = 0; d < N; d++) begin
            ph[d] = M_OFF; t0[d] = -100; pend[d] = 0; err[d] = 0; from_dn[d] = 0;
        end
    endfunction

    function automatic void model_step();
        mphase_t op[N];
        bit      opend[N];
        bit      busy;
        int      winner;
        busy = 0; winner = -1;
        for (int d = 0; d < N; d++) begin
            op[d] = ph[d]; opend[d] = pend[d];
            if (op[d] == M_RAMP) busy = 1;
            if (opend[d] && winner < 0) winner = d;
        end
        for (int d = 0; d < N; d++) begin
            int      el;
            mphase_t nxt;
            bit      set;
            el = cyc - t0[d]; nxt = op[d]; set = 0;
            case (op[d])
                M_OFF: begin
                    if (opend[d] && !busy && winner == d) begin nxt = M_RAMP; pend[d] = 0; end
                    else if (on_req[d]) pend[d] = 1;
                end
                M_RAMP:  if (el == RAMP) nxt = M_REST;
                M_REST:  if (ack[d]) nxt = M_DEISO; else if (el == TMO) begin set = 1; nxt = M_DEISO; end
                M_DEISO: nxt = M_ON;
                M_ON:    if (off_req[d]) nxt = M_ISO;
                M_ISO:   if (el == ISOC) nxt = M_SAVE;
                M_SAVE:  if (ack[d]) nxt = M_DN; else if (el == TMO) begin set = 1; nxt = M_DEISO; end
                default: nxt = M_OFF;
            endcase
            err[d] = set | (err[d] & !clr[d]);
            if (nxt != op[d]) begin
                from_dn[d] = (op[d] == M_DN);
                ph[d] = nxt; t0[d] = cyc;
            end
        end
    endfunction

    task automatic cmp(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic pin(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_iso, e_sw, e_sv, e_rs, e_on, e_oa, e_fa, e_er;
        logic         e_busy;
        e_busy = 0;
        for (int d = 0; d < N; d++) begin
            e_iso[d] = (ph[d] != M_ON);
            e_sw[d]  = (ph[d] != M_OFF) && (ph[d] != M_DN);
            e_sv[d]  = (ph[d] == M_SAVE);
            e_rs[d]  = (ph[d] == M_REST);
            e_on[d]  = (ph[d] == M_ON);
            e_oa[d]  = (ph[d] == M_ON) && (t0[d] == cyc);
            e_fa[d]  = (ph[d] == M_OFF) && (t0[d] == cyc) && from_dn[d];
            e_er[d]  = err[d];
            if (ph[d] == M_RAMP) e_busy = 1;
        end
        cmp("isolate_en", isolate_en, e_iso);
        cmp("power_switch_en", power_switch_en, e_sw);
        cmp("save_state", save_state, e_sv);
        cmp("restore_state", restore_state, e_rs);
        cmp("domain_on", domain_on, e_on);
        cmp("power_on_ack", power_on_ack, e_oa);
        cmp("power_off_ack", power_off_ack, e_fa);
        cmp("err_timeout", err_timeout, e_er);
        cmp("ramp_busy", N'(ramp_busy), N'(e_busy));
    endtask

    // One clock: model advances on the edge, outputs are compared 1 ns later.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_step();
        #1 check_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must react at once.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int t, r_sw, r_rest, r_on, r_save, r_err, n_off;
        int rise[N];
        int p_ack[N];
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; on_req = '0; off_req = '0; ack = '0; clr = '0;
        model_reset();
        step(); step();
        pin("reset_isolate_en", int'(isolate_en), 15);
        pin("reset_switch", int'(power_switch_en), 0);
        rst = 1'b0;
        step();

        // 1: single power-up, ack three cycles after restore starts
        t = cyc; on_req = 4'b0001; step(); on_req = '0;
        r_sw = -1; r_rest = -1; r_on = -1;
        for (int k = 0; k < 40 && r_on < 0; k++) begin
            step();
            if (power_switch_en[0] && r_sw < 0) r_sw = cyc;
            if (restore_state[0] && r_rest < 0) r_rest = cyc;
            if (r_rest >= 0 && cyc == r_rest + 3) ack[0] = 1'b1;
            if (power_on_ack[0]) begin r_on = cyc; ack[0] = 1'b0; end
        end
        ack = '0;
        pin("up_sw_rise", r_sw, t + 2);
        pin("up_restore_rise", r_rest, t + 18);
        pin("up_on_ack", r_on, t + 23);
        pin("up_iso_low", int'(isolate_en[0]), 0);

        // 2: normal power-down
        t = cyc; off_req = 4'b0001; step(); off_req = '0;
        pin("dn_iso_next", int'(isolate_en[0]), 1);
        r_save = -1;
        for (int k = 0; k < 10 && r_save < 0; k++) begin
            step();
            if (save_state[0]) r_save = cyc;
        end
        pin("dn_save_rise", r_save, t + 3);
        ack[0] = 1'b1; step(); ack[0] = 1'b0;
        pin("dn_sw_off", int'(power_switch_en[0]), 0);
        step();
        pin("dn_off_ack", int'(power_off_ack[0]), 1);
        pin("dn_domain_on", int'(domain_on[0]), 0);

        // 3: simultaneous requests ramp strictly in priority order
        t = cyc; on_req = 4'b1110; ack = 4'b1110; step(); on_req = '0;
        for (int d = 0; d < N; d++) rise[d] = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            for (int d = 1; d < N; d++) if (power_switch_en[d] && rise[d] < 0) rise[d] = cyc;
        end
        ack = '0;
        pin("ord_sw1", rise[1], t + 2);
        pin("ord_sw2", rise[2], t + 19);
        pin("ord_sw3", rise[3], t + 36);

        // 4: save timeout aborts back to ON, then err_clr
        on_req[0] = 1'b1; ack[0] = 1'b1; step(); on_req = '0;
        repeat (24) step();
        ack = '0;
        t = cyc; off_req[0] = 1'b1; step(); off_req = '0;
        n_off = 0; r_err = -1; r_on = -1;
        for (int k = 0; k < 90 && r_on < 0; k++) begin
            step();
            if (power_off_ack[0]) n_off++;
            if (err_timeout[0] && r_err < 0) r_err = cyc;
            if (power_on_ack[0]) r_on = cyc;
        end
        pin("tmo_err_rise", r_err, t + 67);
        pin("tmo_back_on", r_on, t + 68);
        pin("tmo_no_off_ack", n_off, 0);
        clr[0] = 1'b1; step(); clr = '0;
        pin("tmo_err_clr", int'(err_timeout[0]), 0);

        // 5: async reset with one domain ramping and one saving
        off_req[0] = 1'b1; ack[0] = 1'b1; step(); off_req = '0;
        repeat (5) step();
        ack = '0;
        on_req[0] = 1'b1; off_req[1] = 1'b1; step(); on_req = '0; off_req = '0;
        repeat (5) step();
        pin("pre_rst_save1", int'(save_state[1]), 1);
        pin("pre_rst_busy", int'(ramp_busy), 1);
        #2 rst = 1'b1;
        #1 model_reset();
        pin("arst_iso", int'(isolate_en), 15);
        pin("arst_sw", int'(power_switch_en), 0);
        pin("arst_save", int'(save_state), 0);
        pin("arst_busy", int'(ramp_busy), 0);
        check_all();
        step(); step();
        rst = 1'b0;

        // 6: ignored requests
        off_req[2] = 1'b1; step(); off_req = '0;
        step(); step();
        pin("ign_off_sw", int'(power_switch_en[2]), 0);
        on_req[2] = 1'b1; ack[2] = 1'b1; step(); on_req = '0;
        repeat (24) step();
        ack = '0;
        off_req[2] = 1'b1; step(); off_req = '0;
        on_req[2] = 1'b1; step(); on_req = '0;
        ack[2] = 1'b1;
        n_off = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (power_off_ack[2]) n_off++;
        end
        ack = '0;
        pin("ign_off_ack_seen", n_off, 1);
        repeat (5) step();
        pin("ign_no_ramp", int'(power_switch_en[2]), 0);

        // Randomized traffic with varying ack likelihood and occasional resets
        for (int d = 0; d < N; d++) p_ack[d] = 50;
        for (int it = 0; it < 3000; it++) begin
            if (it % 200 == 0) begin
                for (int d = 0; d < N; d++) begin
                    case ($urandom_range(3))
                        0:       p_ack[d] = 0;
                        1:       p_ack[d] = 10;
                        2:       p_ack[d] = 40;
                        default: p_ack[d] = 90;
                    endcase
                end
            end
            for (int d = 0; d < N; d++) begin
                on_req[d]  = ($urandom_range(99) < 8);
                off_req[d] = ($urandom_range(99) < 8);
                ack[d]     = ($urandom_range(99) < p_ack[d]);
                clr[d]     = ($urandom_range(99) < 3);
            end
            step();
            if ($urandom_range(999) < 2) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
